// File: rtl/ew_pkg.sv
// Shared types for the EW threat-response FSM and its downstream checker.
package ew_pkg;

    localparam int FSM_BITS = 3;

    // Encoding 7 is deliberately left unused; the checker flags it as illegal.
    typedef enum logic [FSM_BITS-1:0] {
        ST_IDLE             = 3'd0,
        ST_MONITOR          = 3'd1,
        ST_JAMMED           = 3'd2,
        ST_SPOOF_DETECTED   = 3'd3,
        ST_ENTROPY_ANALYZED = 3'd4,
        ST_COUNTER_MEASURE  = 3'd5,
        ST_RECOVERY         = 3'd6
    } fsm_state_t;

    typedef enum logic [1:0] {
        CM_NONE  = 2'd0,
        CM_JAM   = 2'd1,
        CM_SPOOF = 2'd2
    } cm_type_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ew_threat_fsm_if.sv
// Detector/countermeasure bus between the EW receive chain and the threat FSM.
interface ew_threat_fsm_if #(
    parameter int ENT_W    = 8,
    parameter int CNT_W    = 16,
    parameter int FSM_BITS = 3
);
    logic                jam_det;
    logic                spoof_det;
    logic                ent_valid;
    logic [ENT_W-1:0]    ent_value;
    logic                cm_ack;
    logic [FSM_BITS-1:0] fsm_state;
    logic                cm_req;
    logic [1:0]          cm_type;
    logic                timeout_err;
    logic [CNT_W-1:0]    jam_count;
    logic [CNT_W-1:0]    spoof_count;

    // Environment side: drives detector flags and the countermeasure ack.
    modport master (
        output jam_det, spoof_det, ent_valid, ent_value, cm_ack,
        input  fsm_state, cm_req, cm_type, timeout_err, jam_count, spoof_count
    );

    // FSM side.
    modport slave (
        input  jam_det, spoof_det, ent_valid, ent_value, cm_ack,
        output fsm_state, cm_req, cm_type, timeout_err, jam_count, spoof_count
    );
endinterface

// File: rtl/ew_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module ew_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // Increment on request unless already saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/ew_threat_fsm.sv
// Threat-response sequencer: detector flags -> countermeasure handshake -> recovery.
module ew_threat_fsm
    import ew_pkg::*;
#(
    parameter int FSM_BITS        = 3,
    parameter int ENT_W           = 8,
    parameter int ENT_THRESH      = 96,
    parameter int WAIT_TIMEOUT    = 64,
    parameter int RECOVERY_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           rst,
    ew_threat_fsm_if.slave bus
);
    localparam int TMR_W = $clog2(max_int(WAIT_TIMEOUT, RECOVERY_CYCLES) + 1);

    fsm_state_t       state_q, state_d;
    cm_type_t         cm_type_q, cm_type_d;
    logic [TMR_W-1:0] tmr_q;
    logic [ENT_W-1:0] ent_cap_q;
    logic             cm_req_q, terr_q;
    logic             tmo, cap_en, wait_hit, rec_hit, timed;

    // The timer value before an edge equals the number of edges already spent
    // in the state, so "== N-1" makes the exit land on the N-th edge.
    assign wait_hit = (tmr_q == TMR_W'(WAIT_TIMEOUT - 1));
    assign rec_hit  = (tmr_q == TMR_W'(RECOVERY_CYCLES - 1));
    assign timed    = (state_q == ST_SPOOF_DETECTED) || (state_q == ST_COUNTER_MEASURE) ||
                      (state_q == ST_RECOVERY);

    // Next-state, timeout flag and countermeasure type selection.
    always_comb begin
        state_d   = state_q;
        cm_type_d = cm_type_q;
        tmo       = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            ST_IDLE:    state_d = ST_MONITOR;
            ST_MONITOR: begin
                if (bus.jam_det)        state_d = ST_JAMMED;
                else if (bus.spoof_det) state_d = ST_SPOOF_DETECTED;
            end
            ST_JAMMED: begin
                state_d   = ST_COUNTER_MEASURE;
                cm_type_d = CM_JAM;
            end
            ST_SPOOF_DETECTED: begin
                if (bus.ent_valid) begin
                    state_d = ST_ENTROPY_ANALYZED;
                    cap_en  = 1'b1;
                end else if (wait_hit) begin
                    state_d = ST_MONITOR;
                    tmo     = 1'b1;
                end
            end
            ST_ENTROPY_ANALYZED: begin
                if (ent_cap_q < ENT_W'(ENT_THRESH)) begin
                    state_d   = ST_COUNTER_MEASURE;
                    cm_type_d = CM_SPOOF;
                end else begin
                    state_d = ST_MONITOR;
                end
            end
            ST_COUNTER_MEASURE: begin
                // Ack beats a coincident timeout and suppresses the error pulse.
                if (bus.cm_ack) begin
                    state_d = ST_RECOVERY;
                end else if (wait_hit) begin
                    state_d = ST_RECOVERY;
                    tmo     = 1'b1;
                end
            end
            ST_RECOVERY: if (rec_hit) state_d = ST_MONITOR;
            default:     state_d = ST_IDLE;
        endcase
        if (state_d == ST_MONITOR) cm_type_d = CM_NONE;
    end

    // State, shared timer, captured entropy and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cm_type_q <= CM_NONE;
            tmr_q     <= '0;
            ent_cap_q <= '0;
            cm_req_q  <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cm_type_q <= cm_type_d;
            tmr_q     <= (state_d != state_q || !timed) ? '0 : tmr_q + 1'b1;
            if (cap_en) ent_cap_q <= bus.ent_value;
            cm_req_q  <= (state_d == ST_COUNTER_MEASURE);
            terr_q    <= tmo;
        end
    end

    assign bus.fsm_state   = FSM_BITS'(state_q);
    assign bus.cm_req      = cm_req_q;
    assign bus.cm_type     = cm_type_q;
    assign bus.timeout_err = terr_q;

    ew_sat_counter #(.CNT_W(CNT_W)) u_jam_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == ST_MONITOR && state_d == ST_JAMMED),
        .count (bus.jam_count)
    );

    ew_sat_counter #(.CNT_W(CNT_W)) u_spoof_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == ST_MONITOR && state_d == ST_SPOOF_DETECTED),
        .count (bus.spoof_count)
    );
endmodule

// File: tb/tb_ew_threat_fsm.sv
// Directed bench for ew_threat_fsm with a per-cycle expectation queue.
module tb_ew_threat_fsm;
    import ew_pkg::*;

    localparam logic [2:0] IDL = 3'd0, MON = 3'd1, JAM = 3'd2, SPF = 3'd3,
                           ENT = 3'd4, CMS = 3'd5, REC = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic [1:0] ty;
        logic       te;
        logic [3:0] jc;
        logic [3:0] sc;
    } snap_t;

    typedef struct {
        string tag;
        snap_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    logic [3:0] exp_jc = '0;
    logic [3:0] exp_sc = '0;
    exp_t exp_q[$];

    ew_threat_fsm_if #(.ENT_W(8), .CNT_W(4), .FSM_BITS(3)) bus ();

    ew_threat_fsm #(
        .FSM_BITS(3), .ENT_W(8), .ENT_THRESH(96), .WAIT_TIMEOUT(64),
        .RECOVERY_CYCLES(16), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic snap_t observe();
        snap_t s;
        s.st  = bus.fsm_state;
        s.req = bus.cm_req;
        s.ty  = bus.cm_type;
        s.te  = bus.timeout_err;
        s.jc  = bus.jam_count;
        s.sc  = bus.spoof_count;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d req=%0d ty=%0d te=%0d jc=%0d sc=%0d",
                         s.st, s.req, s.ty, s.te, s.jc, s.sc);
    endfunction

    // Scoreboard side: one expectation is consumed shortly after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            exp_t  e;
            snap_t o;
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            assert (o === e.v) else begin
                n_err++;
                $error("FAIL %s: got %s, expected %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    end

    // Called at a falling edge with inputs already set: queues the outputs
    // expected after the next rising edge, then advances one cycle.
    task automatic cyc(input string tag, input logic [2:0] st, input logic req,
                       input logic [1:0] ty, input logic te);
        exp_t e;
        e.tag = tag;
        e.v   = '{st: st, req: req, ty: ty, te: te, jc: exp_jc, sc: exp_sc};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic bump_jc();
        if (exp_jc != 4'hF) exp_jc = exp_jc + 4'd1;
    endtask

    task automatic recovery(input string tag, input logic [1:0] ty, input logic te0);
        cyc(tag, REC, 1'b0, ty, te0);
        repeat (15) cyc(tag, REC, 1'b0, ty, 1'b0);
        cyc({tag, "_exit"}, MON, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic jam_event(input string tag);
        bus.jam_det = 1'b1; bump_jc();
        cyc({tag, "_jammed"}, JAM, 1'b0, 2'd0, 1'b0);
        bus.jam_det = 1'b0;
        cyc({tag, "_cm"}, CMS, 1'b1, 2'd1, 1'b0);
        bus.cm_ack = 1'b1;
        cyc({tag, "_ack"}, REC, 1'b0, 2'd1, 1'b0);
        bus.cm_ack = 1'b0;
        repeat (15) cyc({tag, "_rec"}, REC, 1'b0, 2'd1, 1'b0);
        cyc({tag, "_mon"}, MON, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.jam_det = 1'b0; bus.spoof_det = 1'b0; bus.ent_valid = 1'b0;
        bus.ent_value = '0; bus.cm_ack = 1'b0;
        @(negedge clk);

        // Reset and release.
        repeat (2) cyc("reset", IDL, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        cyc("release_monitor", MON, 1'b0, 2'd0, 1'b0);
        repeat (3) cyc("monitor_hold", MON, 1'b0, 2'd0, 1'b0);

        // Simultaneous jam+spoof: jam priority, ack after 5 CM cycles.
        bus.jam_det = 1'b1; bus.spoof_det = 1'b1; exp_jc = 4'd1;
        cyc("jam_prio", JAM, 1'b0, 2'd0, 1'b0);
        bus.jam_det = 1'b0; bus.spoof_det = 1'b0;
        repeat (5) cyc("jam_cm", CMS, 1'b1, 2'd1, 1'b0);
        bus.cm_ack = 1'b1;
        cyc("jam_ack", REC, 1'b0, 2'd1, 1'b0);
        bus.cm_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.jam_det = (i >= 2 && i <= 4);
            bus.spoof_det = (i == 6);
            cyc("jam_rec_ignore", REC, 1'b0, 2'd1, 1'b0);
        end
        bus.jam_det = 1'b0; bus.spoof_det = 1'b0;
        cyc("jam_rec_exit", MON, 1'b0, 2'd0, 1'b0);

        // Spoof confirmed by low entropy.
        bus.spoof_det = 1'b1; exp_sc = 4'd1;
        cyc("spoof_enter", SPF, 1'b0, 2'd0, 1'b0);
        bus.spoof_det = 1'b0;
        repeat (2) cyc("spoof_wait", SPF, 1'b0, 2'd0, 1'b0);
        bus.ent_valid = 1'b1; bus.ent_value = 8'd40;
        cyc("ent_40", ENT, 1'b0, 2'd0, 1'b0);
        bus.ent_valid = 1'b0; bus.ent_value = 8'd0;
        cyc("spoof_cm", CMS, 1'b1, 2'd2, 1'b0);
        bus.cm_ack = 1'b1;
        cyc("spoof_ack", REC, 1'b0, 2'd2, 1'b0);
        bus.cm_ack = 1'b0;
        repeat (15) cyc("spoof_rec", REC, 1'b0, 2'd2, 1'b0);
        cyc("spoof_rec_exit", MON, 1'b0, 2'd0, 1'b0);

        // False alarms: high entropy and the threshold value itself.
        bus.spoof_det = 1'b1; exp_sc = 4'd2;
        cyc("fa200_enter", SPF, 1'b0, 2'd0, 1'b0);
        bus.spoof_det = 1'b0; bus.ent_valid = 1'b1; bus.ent_value = 8'd200;
        cyc("ent_200", ENT, 1'b0, 2'd0, 1'b0);
        bus.ent_valid = 1'b0;
        cyc("fa200_mon", MON, 1'b0, 2'd0, 1'b0);
        bus.spoof_det = 1'b1; exp_sc = 4'd3;
        cyc("fa96_enter", SPF, 1'b0, 2'd0, 1'b0);
        bus.spoof_det = 1'b0; bus.ent_valid = 1'b1; bus.ent_value = 8'd96;
        cyc("ent_96", ENT, 1'b0, 2'd0, 1'b0);
        bus.ent_valid = 1'b0; bus.ent_value = 8'd0;
        cyc("fa96_mon", MON, 1'b0, 2'd0, 1'b0);

        // Spoof wait timeout: 64 cycles in SPOOF_DETECTED, one error pulse.
        bus.spoof_det = 1'b1; exp_sc = 4'd4;
        cyc("sto_enter", SPF, 1'b0, 2'd0, 1'b0);
        bus.spoof_det = 1'b0;
        repeat (63) cyc("sto_wait", SPF, 1'b0, 2'd0, 1'b0);
        cyc("sto_exit", MON, 1'b0, 2'd0, 1'b1);
        cyc("sto_pulse_end", MON, 1'b0, 2'd0, 1'b0);

        // Ack coinciding with the 64th CM cycle: ack wins, no error.
        bus.jam_det = 1'b1; bump_jc();
        cyc("ack64_jam", JAM, 1'b0, 2'd0, 1'b0);
        bus.jam_det = 1'b0;
        repeat (64) cyc("ack64_cm", CMS, 1'b1, 2'd1, 1'b0);
        bus.cm_ack = 1'b1;
        cyc("ack64_exit", REC, 1'b0, 2'd1, 1'b0);
        bus.cm_ack = 1'b0;
        repeat (15) cyc("ack64_rec", REC, 1'b0, 2'd1, 1'b0);
        cyc("ack64_mon", MON, 1'b0, 2'd0, 1'b0);

        // CM timeout with no ack.
        bus.jam_det = 1'b1; bump_jc();
        cyc("cmto_jam", JAM, 1'b0, 2'd0, 1'b0);
        bus.jam_det = 1'b0;
        repeat (64) cyc("cmto_cm", CMS, 1'b1, 2'd1, 1'b0);
        recovery("cmto", 2'd1, 1'b1);

        // Drive jam events up to 17 total; count must pin at 15.
        repeat (14) jam_event("sat");

        // Asynchronous reset while in COUNTER_MEASURE.
        bus.jam_det = 1'b1; bump_jc();
        cyc("rst_jam", JAM, 1'b0, 2'd0, 1'b0);
        bus.jam_det = 1'b0;
        cyc("rst_cm", CMS, 1'b1, 2'd1, 1'b0);
        #1 rst = 1'b1;
        #1;
        exp_jc = 4'd0; exp_sc = 4'd0;
        n_chk++;
        assert (observe() === snap_t'(0)) else begin
            n_err++;
            $error("FAIL async_reset: got %s, expected %s", fmt(observe()), fmt(snap_t'(0)));
        end
        @(negedge clk);
        cyc("rst_hold", IDL, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        cyc("rst_restart", MON, 1'b0, 2'd0, 1'b0);
        cyc("rst_restart_hold", MON, 1'b0, 2'd0, 1'b0);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $error("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
